// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared XOR-network types, Q-format constants and FSM encoding
package nn_pkg;

    localparam int DW_DEF   = 8;
    localparam int FRAC_DEF = 4;

    typedef logic signed [DW_DEF-1:0] fix_t;

    localparam fix_t ONE_Q = 8'sd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_BIAS,
        ST_ACT,
        ST_DONE
    } state_t;

    // Element 0 in the low byte: w0 = 20, w1 = -22
    localparam logic [2*DW_DEF-1:0] W_DEF = {-8'sd22, 8'sd20};
    localparam fix_t                B_DEF = -8'sd4;

endpackage

// File: rtl/nn_hard_sigmoid.sv
// rtl/nn_hard_sigmoid.sv - combinational hard-sigmoid: (z >>> 2) + 0.5, clamped to [0, 1.0]
module nn_hard_sigmoid #(
    parameter int DW   = 8,
    parameter int FRAC = 4
) (
    input  logic signed [DW-1:0] z_i,
    output logic signed [DW-1:0] y_o
);

    localparam logic signed [DW:0] HALF = (DW+1)'(1 << (FRAC-1));
    localparam logic signed [DW:0] ONE  = (DW+1)'(1 << FRAC);

    logic signed [DW:0] h;

    assign h = (DW+1)'(z_i >>> 2) + HALF;

    always_comb begin
        y_o = h[DW-1:0];
        if (h < 0) begin
            y_o = '0;
        end else if (h > ONE) begin
            y_o = ONE[DW-1:0];
        end
    end

endmodule

// File: rtl/output_layer_neuron.sv
// rtl/output_layer_neuron.sv - XOR output neuron: sequential MAC, bias, narrow, hard-sigmoid; OUTPUT_LAYER_SAT_EN selects saturating narrowing
module output_layer_neuron
    import nn_pkg::*;
#(
    parameter int                     N_IN   = 2,
    parameter int                     DW     = DW_DEF,
    parameter int                     FRAC   = FRAC_DEF,
    parameter logic [N_IN*DW-1:0]     W_INIT = W_DEF,
    parameter logic signed [DW-1:0]   B_INIT = B_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [N_IN*DW-1:0]     a_vec,
    output logic                   ack,
    output logic                   busy,
    output logic signed [DW-1:0]   y,
    output logic signed [DW-1:0]   z_out
);

    localparam int ACC_W = 2*DW + $clog2(N_IN) + 1;
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [DW-1:0]     z_q, z_d;
    logic signed [DW-1:0]     y_q, y_d;
    logic                     ack_q, ack_d;
    logic signed [DW-1:0]     a_q [N_IN];
    logic signed [DW-1:0]     w_arr [N_IN];

    logic                     start;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  s;
    logic signed [DW-1:0]     s_nar;
    logic signed [DW-1:0]     h;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_arr[i] = W_INIT[i*DW +: DW];
        end
    end

    assign start = (state_q == ST_IDLE) && req;

    // Each term floors individually before accumulation
    assign prod = a_q[idx_q] * w_arr[idx_q];
    assign term = ACC_W'(prod >>> FRAC);
    assign s    = acc_q + ACC_W'(B_INIT);

`ifdef OUTPUT_LAYER_SAT_EN
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2**(DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2**(DW-1)));

    always_comb begin
        s_nar = s[DW-1:0];
        if (s > S_MAX) begin
            s_nar = S_MAX[DW-1:0];
        end else if (s < S_MIN) begin
            s_nar = S_MIN[DW-1:0];
        end
    end
`else
    assign s_nar = s[DW-1:0];
`endif

    nn_hard_sigmoid #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_act (
        .z_i (z_q),
        .y_o (h)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        z_d     = z_q;
        y_d     = y_q;
        ack_d   = ack_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + term;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(N_IN-1)) begin
                    state_d = ST_BIAS;
                end
            end
            ST_BIAS: begin
                z_d     = s_nar;
                state_d = ST_ACT;
            end
            ST_ACT: begin
                y_d     = h;
                ack_d   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            z_q     <= '0;
            y_q     <= '0;
            ack_q   <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
            y_q     <= y_d;
            ack_q   <= ack_d;
            if (start) begin
                for (int i = 0; i < N_IN; i++) begin
                    a_q[i] <= a_vec[i*DW +: DW];
                end
            end
        end
    end

    assign ack   = ack_q;
    assign busy  = (state_q != ST_IDLE);
    assign y     = y_q;
    assign z_out = z_q;

endmodule
